// File: rtl/ram_write_buffer.sv
// Posted-write buffer in front of RAM port A. It drains in FIFO order,
// forwards buffered data to reads and bounds how long drain can starve.
module ram_write_buffer #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] up_addr,
    input  logic [DATA_WIDTH-1:0] up_wdata,
    input  logic                  up_write,
    input  logic                  up_read,
    output logic                  up_stall,
    output logic [DATA_WIDTH-1:0] up_rdata,
    output logic                  up_rvalid,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  empty,
    output logic                  err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [SW-1:0]         r_starve;
    logic                  r_miss_pending;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_rd;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_hit_data;
    logic [PW-1:0]         w_idx;
    logic                  w_miss;
    logic                  w_force;
    logic                  w_grant;
    logic                  w_drain;
    logic                  w_push;
    logic                  w_full;
    logic                  w_nonempty;

    // Walk entries oldest to newest so the newest match wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        w_idx      = r_rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PW'(i);
            if (CW'(i) < r_count && r_addr[w_idx] == up_addr) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[w_idx];
            end
        end
    end

    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_rd       = up_read && !up_write && !reset;
    assign w_miss     = w_rd && !w_hit;
    assign w_force    = w_miss && w_nonempty
                        && (r_starve == SW'(STARVE_LIMIT));
    assign w_grant    = w_miss && !w_force;
    assign w_drain    = w_nonempty && !w_grant && !reset;
    assign w_push     = up_write && !w_full && !reset;

    assign up_stall    = !reset && ((up_write && w_full) || w_force);
    assign ram_wren    = w_drain;
    assign ram_address = w_grant ? up_addr : r_addr[r_rd_ptr];
    assign ram_data    = r_data[r_rd_ptr];
    assign empty       = !w_nonempty;
    assign err         = r_err;
    assign up_rvalid   = r_rvalid;
    // Miss data comes straight from the RAM's registered output.
    assign up_rdata    = r_miss_pending ? ram_q : r_rdata;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= up_addr;
            r_data[r_wr_ptr] <= up_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_starve       <= '0;
            r_miss_pending <= 1'b0;
            r_rvalid       <= 1'b0;
            r_rdata        <= '0;
            r_err          <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_drain) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_drain);
            if (w_drain || !w_nonempty) begin
                r_starve <= '0;
            end else if (r_starve != SW'(STARVE_LIMIT)) begin
                r_starve <= r_starve + 1'b1;
            end
            r_miss_pending <= w_grant;
            r_rvalid       <= (w_rd && w_hit) || w_grant;
            if (w_rd && w_hit) r_rdata <= w_hit_data;
            if (up_read && up_write) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ram_write_buffer.sv
// Bench for ram_write_buffer: queue-based reference model checked every
// cycle, directed scenarios with literal values, then random traffic.
module tb_ram_write_buffer;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int DEPTH = 4;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] up_addr = '0;
    logic [DW-1:0] up_wdata = '0;
    logic          up_write = 1'b0;
    logic          up_read = 1'b0;
    logic          up_stall;
    logic [DW-1:0] up_rdata;
    logic          up_rvalid;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;
    logic          empty;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_write_buffer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .DEPTH(DEPTH), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .up_addr(up_addr), .up_wdata(up_wdata),
        .up_write(up_write), .up_read(up_read),
        .up_stall(up_stall), .up_rdata(up_rdata),
        .up_rvalid(up_rvalid), .ram_address(ram_address),
        .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q), .empty(empty), .err(err)
    );

    // RAM port A: registered read, write on wren
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    function automatic logic [DW-1:0] f(int i);
        return 16'(i * 7 + 'h1234);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Reference model
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;
    ent_t          q[$];
    int            starve = 0;
    bit            m_err = 0;
    bit            m_rvalid = 0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] exp_mem [0:1023];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = f(i);
            exp_mem[i] = f(i);
        end
        mem[32] = 16'hCAFE;
        exp_mem[32] = 16'hCAFE;
    end

    always @(negedge clk) begin
        int cnt;
        bit rd, hit, miss, frc, grant, drain, push;
        logic [DW-1:0] hd;
        if (reset) begin
            chk("rst_wren", 32'(ram_wren), 0);
            chk("rst_stall", 32'(up_stall), 0);
            q.delete();
            starve = 0;
            m_err = 0;
            m_rvalid = 0;
            m_rdata = '0;
        end else begin
            cnt = q.size();
            rd = up_read && !up_write;
            hit = 0;
            hd = '0;
            foreach (q[i]) if (q[i].a == up_addr) begin
                hit = 1;
                hd = q[i].d;
            end
            miss = rd && !hit;
            frc = miss && cnt > 0 && starve == SL;
            grant = miss && !frc;
            drain = cnt > 0 && !grant;
            push = up_write && cnt < DEPTH;
            chk("stall", 32'(up_stall),
                32'((up_write && cnt == DEPTH) || frc));
            chk("wren", 32'(ram_wren), 32'(drain));
            chk("empty", 32'(empty), 32'(cnt == 0));
            chk("err", 32'(err), 32'(m_err));
            chk("rvalid", 32'(up_rvalid), 32'(m_rvalid));
            if (m_rvalid) chk("rdata", 32'(up_rdata), 32'(m_rdata));
            if (drain) begin
                chk("drain_addr", 32'(ram_address), 32'(q[0].a));
                chk("drain_data", 32'(ram_data), 32'(q[0].d));
            end
            if (grant) chk("miss_addr", 32'(ram_address), 32'(up_addr));
            m_rvalid = (rd && hit) || grant;
            if (rd && hit) m_rdata = hd;
            else if (grant) m_rdata = exp_mem[up_addr];
            if (drain || cnt == 0) starve = 0;
            else if (starve < SL) starve++;
            if (drain) begin
                exp_mem[q[0].a] = q[0].d;
                void'(q.pop_front());
            end
            if (push) q.push_back('{a: up_addr, d: up_wdata});
            if (up_read && up_write) m_err = 1;
        end
    end

    task automatic drive(input bit rs, input bit r, input bit w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        reset = rs;
        up_read = r;
        up_write = w;
        up_addr = a;
        up_wdata = d;
        #1;
    endtask

    initial begin
        int r;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("t1_empty", 32'(empty), 1);
        chk("t1_wren0", 32'(ram_wren), 0);
        chk("t1_stall0", 32'(up_stall), 0);
        chk("t1_rvalid0", 32'(up_rvalid), 0);
        chk("t1_rdata0", 32'(up_rdata), 0);
        chk("t1_err0", 32'(err), 0);
        drive(0, 0, 1, 10'h005, 16'hBEEF);
        chk("t1_nostall", 32'(up_stall), 0);
        chk("t1_nobypass", 32'(ram_wren), 0);
        drive(0, 0, 0, 0, 0);
        chk("t1_wren", 32'(ram_wren), 1);
        chk("t1_addr", 32'(ram_address), 32'h005);
        chk("t1_data", 32'(ram_data), 32'hBEEF);
        drive(0, 0, 0, 0, 0);
        chk("t1_empty2", 32'(empty), 1);

        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, 10'(10'h070 + k), 16'(16'h7000 + k));
            chk("t2_nostall", 32'(up_stall), 0);
            if (k > 0) chk("t2_order", 32'(ram_address), 32'(10'h070 + k - 1));
            drive(0, 1, 0, 10'(10'h200 + k), 0);
            chk("t2_held", 32'(ram_wren), 0);
        end
        drive(0, 0, 0, 0, 0);
        chk("t2_last", 32'(ram_address), 32'h074);
        drive(0, 0, 0, 0, 0);

        drive(0, 0, 1, 10'h010, 16'h1111);
        drive(0, 0, 1, 10'h010, 16'h2222);
        drive(0, 1, 0, 10'h010, 0);
        chk("t3_drain", 32'(ram_wren), 1);
        chk("t3_stall", 32'(up_stall), 0);
        drive(0, 0, 0, 0, 0);
        chk("t3_rvalid", 32'(up_rvalid), 1);
        chk("t3_rdata", 32'(up_rdata), 32'h2222);

        drive(0, 0, 1, 10'h030, 16'h0001);
        drive(0, 0, 1, 10'h031, 16'h0002);
        drive(0, 1, 0, 10'h020, 0);
        chk("t4_wren0", 32'(ram_wren), 0);
        chk("t4_addr", 32'(ram_address), 32'h020);
        drive(0, 0, 0, 0, 0);
        chk("t4_rvalid", 32'(up_rvalid), 1);
        chk("t4_rdata", 32'(up_rdata), 32'hCAFE);
        chk("t4_resume", 32'(ram_wren), 1);
        drive(0, 0, 0, 0, 0);

        drive(0, 0, 1, 10'h040, 16'h0007);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 10'h050, 0);
            chk("t5_nostall", 32'(up_stall), 0);
        end
        drive(0, 1, 0, 10'h050, 0);
        chk("t5_stall", 32'(up_stall), 1);
        chk("t5_forced", 32'(ram_wren), 1);
        chk("t5_faddr", 32'(ram_address), 32'h040);
        drive(0, 1, 0, 10'h050, 0);
        chk("t5_retry", 32'(up_stall), 0);
        chk("t5_norv", 32'(up_rvalid), 0);
        drive(0, 0, 0, 0, 0);
        chk("t5_rvalid", 32'(up_rvalid), 1);
        chk("t5_rdata", 32'(up_rdata), 32'h1464);

        drive(0, 1, 1, 10'h060, 16'hABCD);
        chk("t6_nostall", 32'(up_stall), 0);
        drive(1, 0, 0, 0, 0);
        chk("t6_err", 32'(err), 1);
        chk("t6_norv", 32'(up_rvalid), 0);
        chk("t6_buffered", 32'(empty), 0);
        drive(0, 0, 0, 0, 0);
        chk("t6_errclr", 32'(err), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_nowren", 32'(ram_wren), 0);
        drive(0, 0, 0, 0, 0);
        chk("t6_ram", 32'(mem[10'h060]), 32'h14D4);

        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            drive(r < 2, r >= 2 && (r < 5 || r >= 45) && r < 80,
                  r >= 2 && r < 45,
                  10'(10'h100 + $urandom_range(0, 7)), 16'($urandom));
        end
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
